// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM controller.
// PWM_DT_W only matters when the build defines PWM_DEADTIME_EN.
package pwm_pkg;
    localparam int PWM_CNT_W = 13;
    localparam int PWM_DT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_t;
endpackage

// File: rtl/pwm_if.sv
// Client-facing bundle of the PWM controller: run/load controls, duty and
// period words, and the status outputs. PWM_DEADTIME_EN adds dt and pwm_out_n.
interface pwm_if #(
    parameter int CNT_W = pwm_pkg::PWM_CNT_W
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DT_W = pwm_pkg::PWM_DT_W
`endif
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] duty_d;
    logic [CNT_W-1:0] period_d;
    logic             pwm_out;
    logic             wrap;
    logic [CNT_W-1:0] cnt;
    logic             running;
`ifdef PWM_DEADTIME_EN
    logic [DT_W-1:0]  dt;
    logic             pwm_out_n;

    modport master (output en, load, duty_d, period_d, dt,
                    input  pwm_out, pwm_out_n, wrap, cnt, running);
    modport slave  (input  en, load, duty_d, period_d, dt,
                    output pwm_out, pwm_out_n, wrap, cnt, running);
`else
    modport master (output en, load, duty_d, period_d,
                    input  pwm_out, wrap, cnt, running);
    modport slave  (input  en, load, duty_d, period_d,
                    output pwm_out, wrap, cnt, running);
`endif
endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time insertion between the raw PWM and a complementary output pair.
// Only compiled when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime #(
    parameter int DT_W = 4
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic            active,
    input  logic            raw,
    input  logic [DT_W-1:0] dt,
    output logic            pwm_out,
    output logic            pwm_out_n
);
    logic            raw_q;
    logic [DT_W-1:0] run_len;
    logic [DT_W-1:0] held;

    function automatic logic [DT_W-1:0] sat_inc(input logic [DT_W-1:0] v);
        return (&v) ? v : v + DT_W'(1);
    endfunction

    // Cycles the raw level has already been held before the current one.
    assign held = (raw == raw_q) ? run_len : '0;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            raw_q     <= 1'b0;
            run_len   <= '0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            raw_q     <= raw;
            run_len   <= sat_inc(held);
            pwm_out   <= active &&  raw && (held >= dt);
            pwm_out_n <= active && !raw && (held >= dt);
        end
    end
endmodule
`endif

// File: rtl/pwm_core.sv
// Double-buffered counter PWM with per-period wrap strobe.
// Defining PWM_DEADTIME_EN routes the raw PWM through pwm_deadtime.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DT_W = PWM_DT_W
`endif
) (
    input logic  ck,
    input logic  rst_n,
    pwm_if.slave bus
);
    pwm_state_t       state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] duty_sh, period_sh;
    logic [CNT_W-1:0] duty_a, period_a;
    logic [CNT_W-1:0] duty_nx, period_nx;
    logic             running_q;
    logic             pwm_raw;
    logic             wrap_c;
    logic             upd;

    assign wrap_c = running_q && (cnt_q == period_a);
    assign upd    = ((state == IDLE) && bus.en) || wrap_c;

    // A load on the update edge goes straight into the active pair.
    assign duty_nx   = bus.load ? bus.duty_d   : duty_sh;
    assign period_nx = bus.load ? bus.period_d : period_sh;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_q     <= '0;
            duty_sh   <= '0;
            period_sh <= '0;
            duty_a    <= '0;
            period_a  <= '0;
            running_q <= 1'b0;
            pwm_raw   <= 1'b0;
        end else begin
            if (bus.load) begin
                duty_sh   <= bus.duty_d;
                period_sh <= bus.period_d;
            end
            if (upd) begin
                duty_a   <= duty_nx;
                period_a <= period_nx;
            end
            pwm_raw <= running_q && (cnt_q < duty_a);
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.en) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
                    if (!bus.en) state <= STOP;
                end
                STOP: begin
                    cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
                    if (bus.en) begin
                        state <= RUN;
                    end else if (wrap_c) begin
                        state     <= IDLE;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt_q     <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wrap    = wrap_c;
    assign bus.cnt     = cnt_q;
    assign bus.running = running_q;

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(.DT_W(DT_W)) u_deadtime (
        .ck        (ck),
        .rst_n     (rst_n),
        .active    (running_q),
        .raw       (pwm_raw),
        .dt        (bus.dt),
        .pwm_out   (bus.pwm_out),
        .pwm_out_n (bus.pwm_out_n)
    );
`else
    assign bus.pwm_out = pwm_raw;
`endif
endmodule

// File: tb/tb_pwm_core.sv
// Self-checking bench for pwm_core: hand-computed vector table, directed
// period sequences, and randomized traffic against a cycle reference model.
module tb_pwm_core;
    import pwm_pkg::*;
    localparam int W = PWM_CNT_W;

    logic ck    = 1'b0;
    logic rst_n = 1'b1;

    pwm_if #(.CNT_W(W)) bus ();
    pwm_core #(.CNT_W(W)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));

    always #5 ck = ~ck;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run/stopping flags, position in period, buffered words.
    bit m_on, m_stop, m_pwm;
    int m_cnt, m_dsh, m_psh, m_da, m_pa;

    typedef struct {
        bit en; bit load; int duty; int period;
        bit e_pwm; bit e_wrap; int e_cnt; bit e_run;
    } vec_t;
    vec_t vt[14];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_wrap();
        return m_on && (m_cnt == m_pa);
    endfunction

    task automatic model_reset();
        m_on = 0; m_stop = 0; m_pwm = 0;
        m_cnt = 0; m_dsh = 0; m_psh = 0; m_da = 0; m_pa = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pwm"},  bus.pwm_out, m_pwm);
        check({tag, "_wrap"}, bus.wrap,    m_wrap());
        check({tag, "_cnt"},  bus.cnt,     m_cnt);
        check({tag, "_run"},  bus.running, m_on);
    endtask

    task automatic tick();
        bit w, en, ld, n_on, n_stop, n_pwm;
        int dd, pd, n_cnt, n_dsh, n_psh, n_da, n_pa;
        w  = m_wrap();
        en = bus.en; ld = bus.load; dd = int'(bus.duty_d); pd = int'(bus.period_d);
        n_pwm = m_on && (m_cnt < m_da);
        n_dsh = ld ? dd : m_dsh;
        n_psh = ld ? pd : m_psh;
        n_da = m_da; n_pa = m_pa;
        if ((!m_on && en) || w) begin
            n_da = ld ? dd : m_dsh;
            n_pa = ld ? pd : m_psh;
        end
        n_on = m_on; n_stop = m_stop;
        if (!m_on) begin
            n_cnt = 0; n_on = en; n_stop = 0;
        end else begin
            n_cnt = w ? 0 : m_cnt + 1;
            if (en) n_stop = 0;
            else if (!m_stop) n_stop = 1;
            else if (w) begin n_on = 0; n_stop = 0; end
        end
        @(posedge ck);
        if (rst_n) begin
            m_on = n_on; m_stop = n_stop; m_pwm = n_pwm; m_cnt = n_cnt;
            m_dsh = n_dsh; m_psh = n_psh; m_da = n_da; m_pa = n_pa;
        end else begin
            model_reset();
        end
        #1;
    endtask

    // Asserts reset between edges and checks outputs clear before the next edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_pwm"},  bus.pwm_out, 0);
        check({tag, "_wrap"}, bus.wrap,    0);
        check({tag, "_cnt"},  bus.cnt,     0);
        check({tag, "_run"},  bus.running, 0);
        @(posedge ck);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_period(input int n, input int load_at, input int ld_d, input int ld_p,
                              output int highs, output int wraps, output int first);
        bit done;
        done = 0; highs = 0; wraps = 0; first = 0;
        for (int i = 0; i < n; i++) begin
            if (!done && load_at >= 0 && int'(bus.cnt) == load_at) begin
                bus.load = 1'b1; bus.duty_d = W'(ld_d); bus.period_d = W'(ld_p);
                done = 1;
            end
            tick();
            bus.load = 1'b0;
            check_model("per");
            if (bus.pwm_out) highs++;
            if (bus.wrap) wraps++;
            if (i == 0) first = int'(bus.pwm_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, w, f, k;
        int seq[4];
        bus.en = 1'b0; bus.load = 1'b0; bus.duty_d = '0; bus.period_d = '0;
`ifdef PWM_DEADTIME_EN
        bus.dt = '0;
`endif
        model_reset();
        do_reset("rst0");

        // Hand-derived cycle table; expected values are after each edge.
        vt[0]  = '{0,1,1,2, 0,0,0,0};
        vt[1]  = '{1,0,1,2, 0,0,0,1};
        vt[2]  = '{1,0,1,2, 1,0,1,1};
        vt[3]  = '{1,0,1,2, 0,1,2,1};
        vt[4]  = '{1,0,1,2, 0,0,0,1};
        vt[5]  = '{1,0,1,2, 1,0,1,1};
        vt[6]  = '{0,0,1,2, 0,1,2,1};
        vt[7]  = '{0,0,1,2, 0,0,0,0};
        vt[8]  = '{0,1,5,0, 0,0,0,0};
        vt[9]  = '{1,0,5,0, 0,1,0,1};
        vt[10] = '{1,0,5,0, 1,1,0,1};
        vt[11] = '{0,0,5,0, 1,1,0,1};
        vt[12] = '{0,0,5,0, 1,0,0,0};
        vt[13] = '{0,0,5,0, 0,0,0,0};
        for (int i = 0; i < 14; i++) begin
            bus.en = vt[i].en; bus.load = vt[i].load;
            bus.duty_d = W'(vt[i].duty); bus.period_d = W'(vt[i].period);
            tick();
            check($sformatf("vec%0d_pwm", i),  bus.pwm_out, vt[i].e_pwm);
            check($sformatf("vec%0d_wrap", i), bus.wrap,    vt[i].e_wrap);
            check($sformatf("vec%0d_cnt", i),  bus.cnt,     vt[i].e_cnt);
            check($sformatf("vec%0d_run", i),  bus.running, vt[i].e_run);
        end
        bus.load = 1'b0;

        // Basic run: period 10, duty 3.
        do_reset("rst1");
        bus.load = 1'b1; bus.duty_d = W'(3); bus.period_d = W'(9);
        tick();
        bus.load = 1'b0; bus.en = 1'b1;
        tick();
        check("basic_edge1_pwm", bus.pwm_out, 0);
        check("basic_edge1_run", bus.running, 1);
        run_period(10, -1, 0, 0, h, w, f);
        check("basic_first_high", f, 1);
        check("basic_highs", h, 3);
        check("basic_wraps", w, 1);
        run_period(10, -1, 0, 0, h, w, f);
        check("basic_highs2", h, 3);

        // Mid-period load, then load on the wrap cycle.
        run_period(10, 4, 7, 9, h, w, f);
        check("mid_cur_highs", h, 3);
        run_period(10, 9, 5, 9, h, w, f);
        check("mid_next_highs", h, 7);
        run_period(10, -1, 0, 0, h, w, f);
        check("wrapload_highs", h, 5);

        // Extremes.
        run_period(10, 9, 0, 9, h, w, f);
        run_period(10, -1, 0, 0, h, w, f);
        check("duty0_highs", h, 0);
        run_period(10, 9, 12, 9, h, w, f);
        run_period(10, -1, 0, 0, h, w, f);
        check("dutybig_highs", h, 10);
        run_period(10, 9, 1, 0, h, w, f);
        run_period(5, -1, 0, 0, h, w, f);
        check("per0_highs", h, 5);
        check("per0_wraps", w, 5);
        run_period(1, 0, 8191, 8191, h, w, f);
        run_period(8192, 100, 3, 9, h, w, f);
        check("full_highs", h, 8191);
        check("full_wraps", w, 1);
        check("full_cnt_end", bus.cnt, 0);
        run_period(10, -1, 0, 0, h, w, f);
        check("after_full_highs", h, 3);

        // Stop at cnt 2: period drains, then idle.
        tick(); tick();
        check("stop_pre_cnt", bus.cnt, 2);
        bus.en = 1'b0;
        k = 0; w = 0;
        while (k < 30) begin
            tick(); check_model("stop"); k++;
            if (bus.wrap) w++;
            if (!bus.running) break;
        end
        check("stop_ticks", k, 8);
        check("stop_wraps", w, 1);
        check("stop_pwm", bus.pwm_out, 0);
        check("stop_cnt", bus.cnt, 0);
        tick(); tick();
        check("idle_run", bus.running, 0);

        // Restart, stop at cnt 2, re-enable at cnt 6: no counter gap.
        bus.en = 1'b1;
        tick(); tick(); tick();
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); check_model("rs"); end
        check("rs_cnt6", bus.cnt, 6);
        bus.en = 1'b1;
        seq = '{7, 8, 9, 0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rs_seq%0d", i), bus.cnt, seq[i]);
            check($sformatf("rs_run%0d", i), bus.running, 1);
        end
        run_period(10, -1, 0, 0, h, w, f);
        check("rs_highs", h, 3);

        // Reset mid-run with pwm_out high.
        run_period(10, 1, 7, 9, h, w, f);
        for (int i = 0; i < 5; i++) tick();
        check("mr_pre_cnt", bus.cnt, 5);
        check("mr_pre_pwm", bus.pwm_out, 1);
        bus.en = 1'b0;
        do_reset("mr");
        for (int i = 0; i < 3; i++) begin tick(); check_model("mr_idle"); end
        bus.en = 1'b1;
        tick();
        check("mr_restart_run", bus.running, 1);
        tick();
        check("mr_restart_pwm", bus.pwm_out, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.period_d = W'($urandom_range(0, 15));
            bus.duty_d   = W'($urandom_range(0, 18));
            if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
            tick();
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
